// File: rtl/eight_by_four_seq_divider.sv
// ---------------------------------------------------------------------------
// eight_by_four_seq_divider
//
// Sequential restoring divider: an 8-bit unsigned dividend divided by a 4-bit
// unsigned divisor. One quotient bit is resolved per clock, MSB first, so a
// nonzero division takes 8 CALC cycles followed by a single DONE cycle.
// A zero divisor skips the arithmetic. It reports quotient 8'hFF, remainder 0
// and raises div_by_zero. That result spends two cycles in DONE, and done is
// high only in the second of them.
//
// Ports
//   clk          : single clock, all state changes on its rising edge
//   rst_n        : synchronous active-low reset
//   start        : begin a division (only looked at while idle)
//   dividend[7:0]: unsigned dividend, captured on the accepting edge
//   divisor[3:0] : unsigned divisor, captured on the accepting edge
//   quotient[7:0]: registered quotient (qualify with done)
//   remainder[3:0]: registered remainder (qualify with done)
//   busy         : high while in CALC or DONE
//   done         : one-cycle pulse, quotient/remainder valid
//   div_by_zero  : registered flag, set for a result produced with divisor 0
// ---------------------------------------------------------------------------
module eight_by_four_seq_divider (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  dividend_r;     // shifted left each step, MSB feeds the remainder
    logic [3:0]  divisor_r;
    logic [7:0]  quotient_r;     // quotient bits shift in from the LSB
    logic [4:0]  pr_r;           // partial remainder, one spare bit for the compare
    logic [2:0]  cnt_r;
    logic        busy_r;
    logic        done_r;
    logic        dbz_r;
    logic        zhold_r;        // divide-by-zero result waits one extra cycle in DONE
    logic        done_s;
    logic [4:0]  pr_shift_s;
    logic [4:0]  pr_next_s;
    logic        ge_s;

    // Next-state decode and the done pulse for the following cycle
    always_comb begin
        state_s = state_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (divisor == 4'd0) begin
                        state_s = DONE;
                    end else begin
                        state_s = CALC;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == 3'd7) begin
                    state_s = DONE;
                    done_s  = 1'b1;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                if (zhold_r) begin
                    state_s = DONE;
                    done_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
                done_s  = 1'b0;
            end
        endcase
    end

    // One restoring step: bring in the next dividend bit, subtract if it fits
    always_comb begin
        pr_shift_s = {pr_r[3:0], dividend_r[7]};
        ge_s       = (pr_shift_s >= {1'b0, divisor_r});
        if (ge_s) begin
            pr_next_s = pr_shift_s - {1'b0, divisor_r};
        end else begin
            pr_next_s = pr_shift_s;
        end
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            dividend_r <= 8'd0;
            divisor_r  <= 4'd0;
            quotient_r <= 8'd0;
            pr_r       <= 5'd0;
            cnt_r      <= 3'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            dbz_r      <= 1'b0;
            zhold_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= done_s;
            case (state_r)
                IDLE: begin
                    if (start && (divisor == 4'd0)) begin
                        quotient_r <= 8'hFF;
                        pr_r       <= 5'd0;
                        dbz_r      <= 1'b1;
                        zhold_r    <= 1'b1;
                    end else if (start) begin
                        dividend_r <= dividend;
                        divisor_r  <= divisor;
                        quotient_r <= 8'd0;
                        pr_r       <= 5'd0;
                        cnt_r      <= 3'd0;
                        dbz_r      <= 1'b0;
                    end else begin
                        // results hold while idle
                        quotient_r <= quotient_r;
                        pr_r       <= pr_r;
                    end
                end
                CALC: begin
                    dividend_r <= {dividend_r[6:0], 1'b0};
                    quotient_r <= {quotient_r[6:0], ge_s};
                    pr_r       <= pr_next_s;
                    cnt_r      <= cnt_r + 3'd1;
                end
                DONE: begin
                    zhold_r <= 1'b0;
                end
                default: begin
                    zhold_r <= 1'b0;
                end
            endcase
        end
    end

    // After every step the partial remainder is below the divisor, so it fits 4 bits
    assign quotient    = quotient_r;
    assign remainder   = pr_r[3:0];
    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_eight_by_four_seq_divider.sv
// ---------------------------------------------------------------------------
// Directed bench for eight_by_four_seq_divider: reset, fixed vectors,
// divide by zero, abort by reset, ignored restart, back-to-back operation,
// and a sweep over every nonzero-divisor operand pair.
// ---------------------------------------------------------------------------
module tb_eight_by_four_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    eight_by_four_seq_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts negedges from now until done is seen, bounded
    task automatic wait_done(output int k);
        k = 0;
        while (done !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Caller is at a negedge; one start pulse, then check the result
    task automatic run_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] eq, input logic [3:0] er, input logic edbz,
                          input int elat);
        int k;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(k);
        chk({tag, " latency"}, 32'(k), 32'(elat));
        chk({tag, " quotient"}, 32'(quotient), 32'(eq));
        chk({tag, " remainder"}, 32'(remainder), 32'(er));
        chk({tag, " dbz"}, 32'(div_by_zero), 32'(edbz));
        @(negedge clk);
        chk({tag, " done pulse width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int k;
        int seen;
        logic [7:0] hq;
        logic [3:0] hr;

        // Reset with a coincident start, which must be ignored
        rst_n    = 1'b0;
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        @(negedge clk);
        @(negedge clk);
        chk("reset quotient", 32'(quotient), 32'd0);
        chk("reset remainder", 32'(remainder), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset dbz", 32'(div_by_zero), 32'd0);

        // First edge with rst_n high accepts; 200/7 = 28 r 4
        rst_n = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy === 1'b1 && done === 1'b0) seen++;
            @(negedge clk);
        end
        chk("200/7 busy calc cycles", 32'(seen), 32'd8);
        chk("200/7 done", 32'(done), 32'd1);
        chk("200/7 busy in done", 32'(busy), 32'd1);
        chk("200/7 quotient", 32'(quotient), 32'd28);
        chk("200/7 remainder", 32'(remainder), 32'd4);
        chk("200/7 dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        chk("200/7 done cleared", 32'(done), 32'd0);
        chk("200/7 busy cleared", 32'(busy), 32'd0);

        run_op("255/1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 8);
        run_op("5/9", 8'd5, 4'd9, 8'd0, 4'd5, 1'b0, 8);
        run_op("15/15", 8'd15, 4'd15, 8'd1, 4'd0, 1'b0, 8);
        run_op("A5/0", 8'hA5, 4'd0, 8'hFF, 4'd0, 1'b1, 1);
        run_op("dbz cleared 17/4", 8'd17, 4'd4, 8'd4, 4'd1, 1'b0, 8);

        // Reset at CALC iteration 4 aborts with no done pulse
        dividend = 8'd50;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort outputs zero", 32'({quotient, remainder, busy, done, div_by_zero}), 32'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        chk("abort no done/busy", 32'(seen), 32'd0);
        run_op("100/3 after abort", 8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 8);

        // Restart mid-CALC and operand changes are ignored; 123/5 = 24 r 3
        dividend = 8'd123;
        divisor  = 4'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        dividend = 8'd17;
        divisor  = 4'd2;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'd99;
        divisor  = 4'd4;
        wait_done(k);
        chk("restart latency", 32'(k + 4), 32'd8);
        chk("restart quotient", 32'(quotient), 32'd24);
        chk("restart remainder", 32'(remainder), 32'd3);
        hq = quotient;
        hr = remainder;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'd24
                || remainder !== 4'd3 || div_by_zero !== 1'b0) seen++;
        end
        chk("idle hold", 32'(seen), 32'd0);
        chk("idle hold quotient", 32'(quotient), 32'(hq));
        chk("idle hold remainder", 32'(remainder), 32'(hr));

        // start held high: back-to-back, 20/6 = 3 r 2, period 10
        dividend = 8'd20;
        divisor  = 4'd6;
        start    = 1'b1;
        wait_done(k);
        chk("b2b first latency", 32'(k), 32'd9);
        @(negedge clk);
        wait_done(k);
        chk("b2b period", 32'(k + 1), 32'd10);
        chk("b2b quotient", 32'(quotient), 32'd3);
        chk("b2b remainder", 32'(remainder), 32'd2);
        start = 1'b0;
        @(negedge clk);

        // start held high with divisor 0: period 3
        dividend = 8'hA5;
        divisor  = 4'd0;
        start    = 1'b1;
        wait_done(k);
        chk("b2b dbz first latency", 32'(k), 32'd2);
        @(negedge clk);
        wait_done(k);
        chk("b2b dbz period", 32'(k + 1), 32'd3);
        chk("b2b dbz quotient", 32'(quotient), 32'hFF);
        chk("b2b dbz flag", 32'(div_by_zero), 32'd1);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Every nonzero-divisor operand pair, checked against the identity
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                dividend = 8'(a);
                divisor  = 4'(b);
                start    = 1'b1;
                @(negedge clk);
                start = 1'b0;
                wait_done(k);
                n_checks++;
                assert (k == 8 && quotient === 8'(a / b) && remainder === 4'(a % b)
                        && remainder < 4'(b)
                        && (32'(quotient) * 32'(b) + 32'(remainder)) == 32'(a)) else begin
                    n_fail++;
                    $error("FAIL sweep %0d/%0d: observed q=%0d r=%0d lat=%0d expected q=%0d r=%0d lat=8",
                           a, b, quotient, remainder, k, a / b, a % b);
                end
                @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eight_by_four_seq_divider.md
EIGHT_BY_FOUR_SEQ_DIVIDER -- requirements
Module: eight_by_four_seq_divider

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset: clk input (1) is the single clock, and all state updates on its rising edge.
REQ-002 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-003 start  input  1  request to begin a division; sampled only in IDLE.
REQ-004 dividend  input  8  unsigned dividend; sampled on the accepting edge only.
REQ-005 divisor  input  4  unsigned divisor; sampled on the accepting edge only.
REQ-006 quotient  output  8  unsigned quotient, registered.
REQ-007 remainder  output  4  unsigned remainder, registered.
REQ-008 busy  output  1  high while in CALC or DONE.
REQ-009 done  output  1  one-cycle pulse marking valid quotient/remainder.
REQ-010 div_by_zero  output  1  registered flag; set for a result produced with divisor 0.
REQ-011 No parameters; widths are fixed at 8/4, as the divide counterpart of the 4x4 multiplier (8-bit product).

Function
REQ-012 FSM states SHALL be IDLE, CALC and DONE.
REQ-013 IDLE with start=1 and divisor!=0 SHALL latch the operands, clear the 8-bit quotient shift register, clear the 5-bit partial remainder and the 3-bit iteration counter, and go to CALC.
REQ-014 IDLE with start=1 and divisor==0 SHALL go directly to DONE, loading quotient=8'hFF, remainder=4'h0 and div_by_zero=1.
REQ-015 An accepted start with divisor!=0 SHALL clear div_by_zero.
REQ-016 CALC SHALL perform one restoring step per cycle, MSB first.
REQ-017 Each CALC step: form pr = {partial_rem[3:0], dividend_bit}; if pr >= divisor, subtract divisor and shift in quotient bit 1, else keep pr and shift in 0.
REQ-018 The partial remainder SHALL be 5 bits wide so that the compare cannot overflow.
REQ-019 CALC SHALL run for exactly 8 cycles, counter values 0..7, and go to DONE after the counter reaches 7.
REQ-020 Latency: with the accepting edge at T, done SHALL be high in the cycle after edge T+8, or after edge T+1 for divisor 0.
REQ-021 In DONE, done SHALL be 1 for exactly one cycle, and the next edge SHALL return to IDLE.
REQ-022 In the DONE cycle, quotient and remainder SHALL satisfy dividend == quotient*divisor + remainder, with remainder < divisor.
REQ-023 quotient, remainder and div_by_zero SHALL hold their values from DONE until the next accepted start; they SHALL NOT change during IDLE.
REQ-024 quotient and remainder MAY show intermediate values during CALC; consumers SHALL qualify them with done.
REQ-025 start asserted while busy=1 SHALL be ignored; it SHALL NOT be queued.
REQ-026 Changes to dividend or divisor after the accepting edge SHALL have no effect on the result in progress.
REQ-027 start held high continuously SHALL produce back-to-back operations, one accept per IDLE visit (a minimum period of 10 cycles, or 3 for divisor 0).
REQ-028 No combinational path SHALL exist from any input to any output.

Reset
REQ-029 When rst_n=0 at a rising edge, the next state SHALL be IDLE.
REQ-030 The same reset edge SHALL set quotient=0, remainder=0, busy=0, done=0 and div_by_zero=0, and clear all internal registers.
REQ-031 Reset asserted during CALC or DONE SHALL abort the operation, with no done pulse.
REQ-032 start coincident with rst_n=0 SHALL be ignored.
REQ-033 The first start SHALL be accepted on the first edge with rst_n=1.

Verification
REQ-034 Stimulus: dividend=200, divisor=7, start pulse -> 8 busy cycles of CALC, then done with quotient=28, remainder=4, div_by_zero=0.
REQ-035 Stimulus: 255/1 -> quotient=255, remainder=0; 5/9 -> quotient=0, remainder=5; 15/15 -> quotient=1, remainder=0.
REQ-036 Stimulus: dividend=8'hA5, divisor=0 -> done two cycles after the accepting edge, with quotient=8'hFF, remainder=0, div_by_zero=1.
REQ-037 Stimulus: rst_n low at CALC iteration 4 -> all outputs 0, no done pulse; a fresh 100/3 afterwards -> quotient=33, remainder=1.
REQ-038 Stimulus: start re-pulsed mid-CALC with different operands -> ignored; the original result is delivered, and the outputs then hold through 5 idle cycles.
REQ-039 Stimulus: exhaustive sweep of all 256x15 nonzero operand pairs -> every result satisfies REQ-022, and multiplying quotient by divisor with the team's 4-bit Dadda multiplier (low 4 bits of quotient when quotient < 16) plus remainder reproduces the dividend.
